store_drain: RTL and testbench
==============================

Name: store_drain

Overview:
- Sits on the read end of the store-queue fifo. Pops entries in pairs: first an address word, then a data word.
- Issues each pair as one write request on a single-outstanding req/ack memory port.
- Has a bounded acknowledge timeout and a sticky error flag.
- Handles the fifo's combinational read port (oldest entry always visible, pop on clock edge), so the memory side sees a clean request/acknowledge handshake.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles mem_req_o stays high without mem_ack_i before the store is abandoned. Must be >= 2.
- CNT_WIDTH, 16, width of the store counter in the optional feature.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- fifo_empty_i  input  1  store-queue fifo empty flag
- fifo_data_i  input  32 (word32_t)  oldest fifo entry, combinational
- fifo_read_o  output  1  pop request to fifo; consumed at posedge
- mem_req_o  output  1  write request valid
- mem_addr_o  output  32 (word32_t)  write address
- mem_wdata_o  output  32 (word32_t)  write data
- mem_ack_i  input  1  write accepted; sampled only while mem_req_o=1
- done_o  output  1  one-cycle pulse: store acknowledged
- busy_o  output  1  state != IDLE
- err_o  output  1  sticky: a store timed out

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, named reset_i.
- Reset values: state=IDLE, fifo_read_o=0, mem_req_o=0, done_o=0, busy_o=0, err_o=0, timeout counter=0. mem_addr_o and mem_wdata_o are reset to 0.
- fifo_read_o is combinational from state and fifo_empty_i:
  - It is 1 only in IDLE or DATA with fifo_empty_i=0.
  - It is forced to 0 while reset_i=1.
  - It is never asserted when fifo_empty_i=1.
- FSM states IDLE, DATA, REQ.
  - IDLE: if fifo_empty_i=0, latch fifo_data_i into the address register, pop, go to DATA. Otherwise stay.
  - DATA: if fifo_empty_i=0, latch fifo_data_i into the data register, pop, go to REQ. Otherwise wait in DATA; the address is held and no timeout applies.
  - REQ: mem_req_o=1. mem_addr_o and mem_wdata_o are stable until the handshake ends.
    - If mem_ack_i=1: go to IDLE, pulse done_o the following cycle, clear the counter.
    - Else if counter == TIMEOUT_CYCLES-1: drop the request, set err_o, go to IDLE, clear the counter, no done_o pulse.
    - Else: increment the counter.
- mem_req_o is decoded from the registered state (glitch-free, no combinational path from mem_ack_i).
- Latency with the fifo pre-filled: address pop in cycle 0, data pop in cycle 1, mem_req_o high in cycle 2. An ack in cycle 2 returns the FSM to IDLE in cycle 3.
- Back-to-back stores: the next address pop occurs in the cycle after the ack, so a pair completes every 3 cycles with zero-wait ack.
- mem_ack_i is ignored outside REQ.
- err_o clears only on reset_i.
- Reset mid-operation (DATA or REQ): return to IDLE next cycle and drop mem_req_o. The partially captured pair is discarded; entries already popped are lost, by design.
- Odd entry count: the FSM waits in DATA indefinitely.

Optional Feature:
- Macro STORE_DRAIN_STATS_EN.
- When defined:
  - Adds output store_cnt_o [CNT_WIDTH-1:0], counting acknowledged stores.
  - Adds output timeout_cnt_o [CNT_WIDTH-1:0], counting timed-out stores.
  - Both reset to 0 on reset_i and wrap modulo 2^CNT_WIDTH.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic store: fifo holds 0x0000_1000, 0xDEAD_BEEF; ack in the first REQ cycle -> two pops in cycles 0 and 1; mem_req_o=1 in cycle 2 with addr=0x1000, wdata=0xDEADBEEF; done_o=1 in cycle 3; busy_o=0 in cycle 3.
- Delayed ack: ack after 5 REQ cycles -> mem_req_o, addr and wdata stable for all 5 cycles plus the ack cycle; a single done_o pulse; err_o=0.
- Timeout: TIMEOUT_CYCLES=4, ack never asserted -> mem_req_o high exactly 4 cycles, then 0; err_o=1 and stays 1 through later good stores; no done_o pulse.
- Starved data: only the address 0x2000 in the fifo for 10 cycles, then data 0x55 arrives -> FSM holds in DATA with fifo_read_o=0; pops 0x55 on arrival; issues addr=0x2000, wdata=0x55.
- Throughput: 6 entries (3 pairs), ack always 1 -> 3 done_o pulses spaced exactly 3 cycles apart; fifo_read_o never high while fifo_empty_i=1.
- Reset in REQ: reset_i asserted for 1 cycle while mem_req_o=1 -> mem_req_o=0 and busy_o=0 next cycle; err_o=0; no done_o. With STORE_DRAIN_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/store_drain.sv
// Store-queue drain: pops address/data pairs from a show-ahead fifo and issues
// each pair as one write on a single-outstanding req/ack port.
// Optional build macro: STORE_DRAIN_STATS_EN adds store/timeout counters.
module store_drain #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        fifo_empty_i,
   input  logic [31:0] fifo_data_i,
   output logic        fifo_read_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   output logic        done_o,
   output logic        busy_o,
   output logic        err_o
`ifdef STORE_DRAIN_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] store_cnt_o,
   output logic [CNT_WIDTH-1:0] timeout_cnt_o
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] REQ  = 2'd2;

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   if (TIMEOUT_CYCLES < 2 || CNT_WIDTH < 1) begin : g_bad_param
      $error("store_drain: TIMEOUT_CYCLES must be >= 2 and CNT_WIDTH >= 1");
   end

   logic [1:0]    state;
   logic [TW-1:0] to_cnt;

   // Request and busy decode straight from the registered state: no path from mem_ack_i.
   assign mem_req_o   = (state == REQ);
   assign busy_o      = (state != IDLE);
   assign fifo_read_o = !reset_i && !fifo_empty_i && ((state == IDLE) || (state == DATA));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= IDLE;
         to_cnt      <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty_i) begin
                  mem_addr_o <= fifo_data_i;
                  state      <= DATA;
               end
            end
            DATA: begin
               // An odd entry count parks here with the address held; no timeout yet.
               if (!fifo_empty_i) begin
                  mem_wdata_o <= fifo_data_i;
                  to_cnt      <= '0;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (mem_ack_i) begin
                  done_o <= 1'b1;
                  to_cnt <= '0;
                  state  <= IDLE;
               end else if (to_cnt == TO_LAST) begin
                  err_o  <= 1'b1;
                  to_cnt <= '0;
                  state  <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               to_cnt <= '0;
            end
         endcase
      end
   end

`ifdef STORE_DRAIN_STATS_EN
   // Both counters wrap naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         store_cnt_o   <= '0;
         timeout_cnt_o <= '0;
      end else if (state == REQ) begin
         if (mem_ack_i) begin
            store_cnt_o <= store_cnt_o + CNT_WIDTH'(1);
         end else if (to_cnt == TO_LAST) begin
            timeout_cnt_o <= timeout_cnt_o + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: a table of per-cycle vectors plus hand-written
// sequences for throughput, reset during a request and the ack timeout.
module tb_store_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared fifo model (show-ahead) ----------------
   logic [31:0] fmem [0:63];
   int          wr = 0;
   int          rd = 0;
   logic        sel = 1'b0;   // 0: main instance owns the fifo, 1: timeout instance
   logic        rst = 1'b1;
   logic        m_ack = 1'b0;
   logic        t_ack = 1'b0;

   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        pop;
   logic        m_empty, t_empty;

   assign fifo_empty = (rd == wr);
   assign fifo_data  = fmem[rd[5:0]];
   assign m_empty    = fifo_empty | sel;
   assign t_empty    = fifo_empty | ~sel;

   logic        m_read, m_req, m_done, m_busy, m_err;
   logic [31:0] m_addr, m_wdata;
   logic        t_read, t_req, t_done, t_busy, t_err;
   logic [31:0] t_addr, t_wdata;
`ifdef STORE_DRAIN_STATS_EN
   logic [15:0] m_scnt, m_tcnt, t_scnt, t_tcnt;
`endif

   assign pop = sel ? t_read : m_read;

   always @(posedge clk) begin
      if (pop && (rd != wr)) rd <= rd + 1;
   end

   store_drain dut (
      .clk_i(clk), .reset_i(rst), .fifo_empty_i(m_empty), .fifo_data_i(fifo_data),
      .fifo_read_o(m_read), .mem_req_o(m_req), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
      .mem_ack_i(m_ack), .done_o(m_done), .busy_o(m_busy), .err_o(m_err)
`ifdef STORE_DRAIN_STATS_EN
      , .store_cnt_o(m_scnt), .timeout_cnt_o(m_tcnt)
`endif
   );

   store_drain #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk_i(clk), .reset_i(rst), .fifo_empty_i(t_empty), .fifo_data_i(fifo_data),
      .fifo_read_o(t_read), .mem_req_o(t_req), .mem_addr_o(t_addr), .mem_wdata_o(t_wdata),
      .mem_ack_i(t_ack), .done_o(t_done), .busy_o(t_busy), .err_o(t_err)
`ifdef STORE_DRAIN_STATS_EN
      , .store_cnt_o(t_scnt), .timeout_cnt_o(t_tcnt)
`endif
   );

   // ---------------- driver tasks and checker ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic push_word(input logic [31:0] v);
      fmem[wr] = v;
      wr = wr + 1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic        rst;
      logic        ack;
      logic        push;
      logic [31:0] push_val;
      logic        exp_read;
      logic        exp_req;
      logic        exp_done;
      logic        exp_busy;
      logic        exp_err;
      logic        chk_bus;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string nm, input logic r, input logic a, input logic p,
                               input logic [31:0] pv, input logic erd, input logic erq,
                               input logic edn, input logic ebz, input logic eer,
                               input logic cb, input logic [31:0] ea, input logic [31:0] ew);
      vec_t v;
      v.name = nm; v.rst = r; v.ack = a; v.push = p; v.push_val = pv;
      v.exp_read = erd; v.exp_req = erq; v.exp_done = edn; v.exp_busy = ebz; v.exp_err = eer;
      v.chk_bus = cb; v.exp_addr = ea; v.exp_wdata = ew;
      vecs.push_back(v);
   endfunction

   // ---------------- scoreboard for throughput ----------------
   logic [63:0] exp_q[$];
   int          done_cyc[$];
   int          viol;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) fmem[i] = '0;
      repeat (2) @(negedge clk);

      //   name          rst ack push val           rd req dn bz er  bus addr          wdata
      add("rst_push_a",   1,  0,  1, 32'h0000_1000, 0, 0, 0, 0, 0,  1, 32'h0,        32'h0);
      add("rst_push_d",   1,  0,  1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,  1, 32'h0,        32'h0);
      add("basic_c0",     0,  0,  0, 32'h0,         1, 0, 0, 0, 0,  0, 32'h0,        32'h0);
      add("basic_c1",     0,  0,  0, 32'h0,         1, 0, 0, 1, 0,  0, 32'h0,        32'h0);
      add("basic_c2",     0,  1,  0, 32'h0,         0, 1, 0, 1, 0,  1, 32'h0000_1000, 32'hDEAD_BEEF);
      add("basic_c3",     0,  0,  0, 32'h0,         0, 0, 1, 0, 0,  0, 32'h0,        32'h0);
      add("basic_c4",     0,  0,  0, 32'h0,         0, 0, 0, 0, 0,  0, 32'h0,        32'h0);
      add("dly_a",        0,  0,  1, 32'h0000_00A0, 1, 0, 0, 0, 0,  0, 32'h0,        32'h0);
      add("dly_d",        0,  0,  1, 32'h0000_00B1, 1, 0, 0, 1, 0,  0, 32'h0,        32'h0);
      for (int k = 0; k < 5; k++)
         add("dly_wait",  0,  0,  0, 32'h0,         0, 1, 0, 1, 0,  1, 32'hA0,       32'hB1);
      add("dly_ack",      0,  1,  0, 32'h0,         0, 1, 0, 1, 0,  1, 32'hA0,       32'hB1);
      add("dly_done",     0,  0,  0, 32'h0,         0, 0, 1, 0, 0,  0, 32'h0,        32'h0);
      add("dly_idle",     0,  0,  0, 32'h0,         0, 0, 0, 0, 0,  0, 32'h0,        32'h0);
      add("stv_a",        0,  0,  1, 32'h0000_2000, 1, 0, 0, 0, 0,  0, 32'h0,        32'h0);
      // ack toggles while starved: it must be ignored outside REQ
      for (int k = 0; k < 10; k++)
         add("stv_wait",  0, logic'(k % 2), 0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0,    32'h0);
      add("stv_d",        0,  0,  1, 32'h0000_0055, 1, 0, 0, 1, 0,  0, 32'h0,        32'h0);
      add("stv_req",      0,  1,  0, 32'h0,         0, 1, 0, 1, 0,  1, 32'h2000,     32'h55);
      add("stv_done",     0,  0,  0, 32'h0,         0, 0, 1, 0, 0,  0, 32'h0,        32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst   = vecs[i].rst;
         m_ack = vecs[i].ack;
         if (vecs[i].push) push_word(vecs[i].push_val);
         #1;
         chk($sformatf("%s[%0d].read", vecs[i].name, i), 64'(m_read), 64'(vecs[i].exp_read));
         chk($sformatf("%s[%0d].req",  vecs[i].name, i), 64'(m_req),  64'(vecs[i].exp_req));
         chk($sformatf("%s[%0d].done", vecs[i].name, i), 64'(m_done), 64'(vecs[i].exp_done));
         chk($sformatf("%s[%0d].busy", vecs[i].name, i), 64'(m_busy), 64'(vecs[i].exp_busy));
         chk($sformatf("%s[%0d].err",  vecs[i].name, i), 64'(m_err),  64'(vecs[i].exp_err));
         if (vecs[i].chk_bus) begin
            chk($sformatf("%s[%0d].addr",  vecs[i].name, i), 64'(m_addr),  64'(vecs[i].exp_addr));
            chk($sformatf("%s[%0d].wdata", vecs[i].name, i), 64'(m_wdata), 64'(vecs[i].exp_wdata));
         end
         @(negedge clk);
      end
      m_ack = 1'b0;

      // ---------------- throughput: 3 pairs, ack always high ----------------
      @(negedge clk);
      m_ack = 1'b1;
      viol  = 0;
      for (int j = 0; j < 3; j++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = 32'h3000 + 32'(4 * j);
         d = 32'h11 * 32'(j + 1);
         push_word(a);
         push_word(d);
         exp_q.push_back({a, d});
      end
      for (int c = 0; c < 14; c++) begin
         #1;
         if (m_read && m_empty) viol++;
         if (m_req && m_ack) begin
            if (exp_q.size() == 0) chk("tput_extra_req", 64'(1), 64'(0));
            else chk("tput_bus", {m_addr, m_wdata}, exp_q.pop_front());
         end
         if (m_done) done_cyc.push_back(c);
         @(negedge clk);
      end
      m_ack = 1'b0;
      chk("tput_ndone", 64'(done_cyc.size()), 64'(3));
      for (int j = 0; j < done_cyc.size(); j++)
         chk($sformatf("tput_done_cycle[%0d]", j), 64'(done_cyc[j]), 64'(3 * (j + 1)));
      chk("tput_read_when_empty", 64'(viol), 64'(0));
      chk("tput_left_in_q", 64'(exp_q.size()), 64'(0));

      // ---------------- reset while in REQ ----------------
      push_word(32'h4000);
      push_word(32'h4444);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rreq_req_before", 64'(m_req), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rreq_req", 64'(m_req), 64'(0));
      chk("rreq_busy", 64'(m_busy), 64'(0));
      chk("rreq_err", 64'(m_err), 64'(0));
      chk("rreq_done", 64'(m_done), 64'(0));
`ifdef STORE_DRAIN_STATS_EN
      chk("rreq_store_cnt", 64'(m_scnt), 64'(0));
      chk("rreq_timeout_cnt", 64'(m_tcnt), 64'(0));
`endif
      @(negedge clk);
      #1;
      chk("rreq_done_next", 64'(m_done), 64'(0));
      chk("rreq_busy_next", 64'(m_busy), 64'(0));

      // ---------------- timeout on the TIMEOUT_CYCLES=4 instance ----------------
      @(negedge clk);
      sel   = 1'b1;
      t_ack = 1'b0;
      push_word(32'h5000);
      push_word(32'h5555);
      #1;
      chk("to_c0_read", 64'(t_read), 64'(1));
      @(negedge clk);
      #1;
      chk("to_c1_read", 64'(t_read), 64'(1));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("to_req[%0d]", k), 64'(t_req), 64'(1));
         chk($sformatf("to_done[%0d]", k), 64'(t_done), 64'(0));
      end
      @(negedge clk);
      #1;
      chk("to_req_dropped", 64'(t_req), 64'(0));
      chk("to_err_set", 64'(t_err), 64'(1));
      chk("to_busy", 64'(t_busy), 64'(0));
      chk("to_no_done", 64'(t_done), 64'(0));
      @(negedge clk);
      #1;
      chk("to_no_done_late", 64'(t_done), 64'(0));
      t_ack = 1'b1;
      push_word(32'h6000);
      push_word(32'h6666);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("to_good_req", 64'(t_req), 64'(1));
      chk("to_good_bus", {t_addr, t_wdata}, {32'h6000, 32'h6666});
      @(negedge clk);
      #1;
      chk("to_good_done", 64'(t_done), 64'(1));
      chk("to_err_sticky", 64'(t_err), 64'(1));
`ifdef STORE_DRAIN_STATS_EN
      chk("to_store_cnt", 64'(t_scnt), 64'(1));
      chk("to_timeout_cnt", 64'(t_tcnt), 64'(1));
`endif
      t_ack = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
